// File: rtl/baccarat_ctrl_if.sv
// Signal bundle between the baccarat round controller and its card/bet datapath.
// The controller uses the slave modport; the datapath (or a bench) uses master.
interface baccarat_ctrl_if;
    logic       start;
    logic [3:0] pcard3_out;
    logic [3:0] pscore_out;
    logic [3:0] dscore_out;
    logic       betenabled;
    logic       load_pcard1;
    logic       load_pcard2;
    logic       load_pcard3;
    logic       load_dcard1;
    logic       load_dcard2;
    logic       load_dcard3;
    logic       update_bal;
    logic       player_win;
    logic       dealer_win;
    logic       tie;
    logic       clear_hand;

    modport slave (
        input  start, pcard3_out, pscore_out, dscore_out,
        output betenabled, load_pcard1, load_pcard2, load_pcard3,
               load_dcard1, load_dcard2, load_dcard3,
               update_bal, player_win, dealer_win, tie, clear_hand
    );

    modport master (
        output start, pcard3_out, pscore_out, dscore_out,
        input  betenabled, load_pcard1, load_pcard2, load_pcard3,
               load_dcard1, load_dcard2, load_dcard3,
               update_bal, player_win, dealer_win, tie, clear_hand
    );
endinterface

// File: rtl/baccarat_ctrl.sv
// Round sequencer for baccarat: bet capture, four-card deal, third-card rules, result, balance strobe.
// Optional macro AUTO_NEXT_ROUND_EN: hold DONE for HOLD_CYCLES, pulse clear_hand, return to IDLE.
module baccarat_ctrl #(
    parameter int unsigned HOLD_CYCLES = 8,
    parameter int unsigned CNT_W       = 8
) (
    input  logic           slow_clock,
    input  logic           resetb,
    baccarat_ctrl_if.slave bus
);

    if (HOLD_CYCLES == 0 || (CNT_W < 32 && HOLD_CYCLES >= (32'd1 << CNT_W))) begin : g_bad_hold
        $error("baccarat_ctrl: HOLD_CYCLES must be in 1 .. 2**CNT_W-1");
    end

    typedef enum logic [3:0] {
        S_IDLE, S_P1, S_D1, S_P2, S_D2, S_EVAL_P, S_P3,
        S_EVAL_D, S_D3, S_RESULT, S_UPDATE, S_DONE, S_CLEAR
    } state_t;

    state_t     r_state, w_next_state;
    logic       r_start_q;
    logic       r_pdrew, w_pdrew_next;
    logic       r_player_win, w_player_win_next;
    logic       r_dealer_win, w_dealer_win_next;
    logic       r_tie, w_tie_next;
    logic       w_natural;
    logic       w_banker_draws;
    logic [3:0] w_pval;

    logic r_betenabled, w_betenabled;
    logic r_load_pcard1, w_load_pcard1;
    logic r_load_pcard2, w_load_pcard2;
    logic r_load_pcard3, w_load_pcard3;
    logic r_load_dcard1, w_load_dcard1;
    logic r_load_dcard2, w_load_dcard2;
    logic r_load_dcard3, w_load_dcard3;
    logic r_update_bal,  w_update_bal;

`ifdef AUTO_NEXT_ROUND_EN
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    logic [CNT_W-1:0] r_hold_cnt, w_hold_cnt_next;
    logic             r_clear_hand, w_clear_hand;
`endif

    assign w_natural = (bus.pscore_out >= 4'd8) || (bus.dscore_out >= 4'd8);

    // Banker third-card rule; face cards and tens count as zero
    always_comb begin
        w_pval         = (bus.pcard3_out >= 4'd10) ? 4'd0 : bus.pcard3_out;
        w_banker_draws = 1'b0;
        if (!r_pdrew) begin
            w_banker_draws = (bus.dscore_out <= 4'd5);
        end else begin
            case (bus.dscore_out)
                4'd0, 4'd1, 4'd2: w_banker_draws = 1'b1;
                4'd3:    w_banker_draws = (w_pval != 4'd8);
                4'd4:    w_banker_draws = (w_pval >= 4'd2) && (w_pval <= 4'd7);
                4'd5:    w_banker_draws = (w_pval >= 4'd4) && (w_pval <= 4'd7);
                4'd6:    w_banker_draws = (w_pval >= 4'd6) && (w_pval <= 4'd7);
                default: w_banker_draws = 1'b0;
            endcase
        end
    end

    // Next-state and side registers
    always_comb begin
        w_next_state      = r_state;
        w_pdrew_next      = r_pdrew;
        w_player_win_next = r_player_win;
        w_dealer_win_next = r_dealer_win;
        w_tie_next        = r_tie;
`ifdef AUTO_NEXT_ROUND_EN
        w_hold_cnt_next   = '0;
`endif
        case (r_state)
            S_IDLE: begin
                w_pdrew_next = 1'b0;
                if (bus.start && !r_start_q) w_next_state = S_P1;
            end
            S_P1:     w_next_state = S_D1;
            S_D1:     w_next_state = S_P2;
            S_P2:     w_next_state = S_D2;
            S_D2:     w_next_state = S_EVAL_P;
            S_EVAL_P: begin
                if (w_natural) begin
                    w_next_state = S_RESULT;
                end else if (bus.pscore_out <= 4'd5) begin
                    w_next_state = S_P3;
                    w_pdrew_next = 1'b1;
                end else begin
                    w_next_state = S_EVAL_D;
                    w_pdrew_next = 1'b0;
                end
            end
            S_P3:     w_next_state = S_EVAL_D;
            S_EVAL_D: w_next_state = w_banker_draws ? S_D3 : S_RESULT;
            S_D3:     w_next_state = S_RESULT;
            S_RESULT: begin
                w_player_win_next = (bus.pscore_out >  bus.dscore_out);
                w_dealer_win_next = (bus.pscore_out <  bus.dscore_out);
                w_tie_next        = (bus.pscore_out == bus.dscore_out);
                w_next_state      = S_UPDATE;
            end
            S_UPDATE: w_next_state = S_DONE;
            S_DONE: begin
`ifdef AUTO_NEXT_ROUND_EN
                if (r_hold_cnt == HOLD_LAST) w_next_state = S_CLEAR;
                else w_hold_cnt_next = CNT_W'(r_hold_cnt + 1'b1);
`endif
            end
            S_CLEAR: begin
                w_player_win_next = 1'b0;
                w_dealer_win_next = 1'b0;
                w_tie_next        = 1'b0;
                w_next_state      = S_IDLE;
            end
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Moore strobes decoded from the upcoming state so they leave a flop cleanly
    always_comb begin
        w_betenabled  = (w_next_state == S_IDLE);
        w_load_pcard1 = (w_next_state == S_P1);
        w_load_dcard1 = (w_next_state == S_D1);
        w_load_pcard2 = (w_next_state == S_P2);
        w_load_dcard2 = (w_next_state == S_D2);
        w_load_pcard3 = (w_next_state == S_P3);
        w_load_dcard3 = (w_next_state == S_D3);
        w_update_bal  = (w_next_state == S_UPDATE);
`ifdef AUTO_NEXT_ROUND_EN
        w_clear_hand  = (w_next_state == S_CLEAR);
`endif
    end

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            r_state       <= S_IDLE;
            r_start_q     <= 1'b0;
            r_pdrew       <= 1'b0;
            r_player_win  <= 1'b0;
            r_dealer_win  <= 1'b0;
            r_tie         <= 1'b0;
            r_betenabled  <= 1'b1;
            r_load_pcard1 <= 1'b0;
            r_load_pcard2 <= 1'b0;
            r_load_pcard3 <= 1'b0;
            r_load_dcard1 <= 1'b0;
            r_load_dcard2 <= 1'b0;
            r_load_dcard3 <= 1'b0;
            r_update_bal  <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_start_q     <= bus.start;
            r_pdrew       <= w_pdrew_next;
            r_player_win  <= w_player_win_next;
            r_dealer_win  <= w_dealer_win_next;
            r_tie         <= w_tie_next;
            r_betenabled  <= w_betenabled;
            r_load_pcard1 <= w_load_pcard1;
            r_load_pcard2 <= w_load_pcard2;
            r_load_pcard3 <= w_load_pcard3;
            r_load_dcard1 <= w_load_dcard1;
            r_load_dcard2 <= w_load_dcard2;
            r_load_dcard3 <= w_load_dcard3;
            r_update_bal  <= w_update_bal;
        end
    end

`ifdef AUTO_NEXT_ROUND_EN
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            r_hold_cnt   <= '0;
            r_clear_hand <= 1'b0;
        end else begin
            r_hold_cnt   <= w_hold_cnt_next;
            r_clear_hand <= w_clear_hand;
        end
    end
    assign bus.clear_hand = r_clear_hand;
`else
    assign bus.clear_hand = 1'b0;
`endif

    assign bus.betenabled  = r_betenabled;
    assign bus.load_pcard1 = r_load_pcard1;
    assign bus.load_pcard2 = r_load_pcard2;
    assign bus.load_pcard3 = r_load_pcard3;
    assign bus.load_dcard1 = r_load_dcard1;
    assign bus.load_dcard2 = r_load_dcard2;
    assign bus.load_dcard3 = r_load_dcard3;
    assign bus.update_bal  = r_update_bal;
    assign bus.player_win  = r_player_win;
    assign bus.dealer_win  = r_dealer_win;
    assign bus.tie         = r_tie;

endmodule

// File: tb/tb_baccarat_ctrl.sv
// Self-checking bench for baccarat_ctrl: card datapath stand-in, directed table, random rounds
// scored by a rules-level model, and a reset-during-deal sequence.
module tb_baccarat_ctrl;
    localparam int unsigned HOLD = 8;

    logic slow_clock = 1'b0;
    logic resetb     = 1'b1;

    baccarat_ctrl_if bus ();

    baccarat_ctrl #(.HOLD_CYCLES(HOLD), .CNT_W(8)) dut (
        .slow_clock (slow_clock),
        .resetb     (resetb),
        .bus        (bus)
    );

    always #5 slow_clock = ~slow_clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Datapath stand-in: deals cards from a per-round deck in the order the strobes ask for them
    logic [5:0][3:0] deck;
    logic [3:0]      pc1, pc2, pc3, dc1, dc2, dc3;
    int              deck_idx;

    function automatic int pts(input logic [3:0] r);
        return (r >= 4'd10) ? 0 : int'(r);
    endfunction

    assign bus.pscore_out = 4'((pts(pc1) + pts(pc2) + pts(pc3)) % 10);
    assign bus.dscore_out = 4'((pts(dc1) + pts(dc2) + pts(dc3)) % 10);
    assign bus.pcard3_out = pc3;

    always @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            {pc1, pc2, pc3, dc1, dc2, dc3} <= '0;
            deck_idx <= 0;
        end else if (bus.clear_hand) begin
            {pc1, pc2, pc3, dc1, dc2, dc3} <= '0;
            deck_idx <= 0;
        end else if (deck_idx < 6 && (bus.load_pcard1 | bus.load_pcard2 | bus.load_pcard3 |
                                      bus.load_dcard1 | bus.load_dcard2 | bus.load_dcard3)) begin
            if (bus.load_pcard1) pc1 <= deck[deck_idx];
            if (bus.load_pcard2) pc2 <= deck[deck_idx];
            if (bus.load_pcard3) pc3 <= deck[deck_idx];
            if (bus.load_dcard1) dc1 <= deck[deck_idx];
            if (bus.load_dcard2) dc2 <= deck[deck_idx];
            if (bus.load_dcard3) dc3 <= deck[deck_idx];
            deck_idx <= deck_idx + 1;
        end
    end

    function automatic logic [11:0] outs();
        return {bus.betenabled, bus.load_pcard1, bus.load_pcard2, bus.load_pcard3,
                bus.load_dcard1, bus.load_dcard2, bus.load_dcard3, bus.update_bal,
                bus.player_win, bus.dealer_win, bus.tie, bus.clear_hand};
    endfunction

    task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", what, act, exp);
        end
    endtask

    function automatic logic [5:0][3:0] mk(input int c0, c1, c2, c3, c4, c5);
        logic [5:0][3:0] c;
        c[0] = 4'(c0); c[1] = 4'(c1); c[2] = 4'(c2);
        c[3] = 4'(c3); c[4] = 4'(c4); c[5] = 4'(c5);
        return c;
    endfunction

    // Banker rule when the player took a third card worth v
    function automatic bit banker_after_player(input int d, input int v);
        if (d <= 2) return 1'b1;
        if (d == 3) return v != 8;
        if (d >= 4 && d <= 6) return (v <= 7) && (v >= 2 * (d - 3));
        return 1'b0;
    endfunction

    // Plays the round from the deck by the rules; res 0=player,1=dealer,2=tie
    task automatic model(input logic [5:0][3:0] c, output bit p3, output bit d3,
                         output int res, output int lat);
        int p, d, k, v;
        p = (pts(c[0]) + pts(c[2])) % 10;
        d = (pts(c[1]) + pts(c[3])) % 10;
        k = 4; p3 = 1'b0; d3 = 1'b0;
        lat = 7;
        if (p < 8 && d < 8) begin
            lat++;
            if (p <= 5) begin
                p3 = 1'b1; v = pts(c[4]); p = (p + v) % 10; k = 5; lat++;
                d3 = banker_after_player(d, v);
            end else begin
                d3 = (d <= 5);
            end
            if (d3) begin
                d = (d + pts(c[k])) % 10; lat++;
            end
        end
        res = (p > d) ? 0 : (p < d) ? 1 : 2;
    endtask

    task automatic reset_dut();
        bus.start = 1'b0;
        resetb = 1'b0;
        #2;
        check("reset_outputs", 32'(outs()), 32'h800);
        @(posedge slow_clock); #1;
        resetb = 1'b1;
    endtask

    task automatic run_round(input string name, input logic [5:0][3:0] cards, input bit do_rst,
                             input bit e_p3, input bit e_d3, input int e_res, input int e_lat);
        int          seq_code, exp_code, multi, n_upd, upd_cyc, n_clr, clr_cyc, nload;
        logic [11:0] o;
        logic [2:0]  exp_flags;
        seq_code = 0; multi = 0; n_upd = 0; upd_cyc = -1; n_clr = 0; clr_cyc = -1;
        deck = cards;
        if (do_rst) reset_dut();
        bus.start = 1'b0;
        @(posedge slow_clock); #1;
        check($sformatf("%s/idle", name), 32'(outs()), 32'h800);
        bus.start = 1'b1;
        o = '0;
        for (int cyc = 1; cyc <= 24; cyc++) begin
            @(posedge slow_clock); #1;
            o = outs();
            nload = 0;
            for (int k = 0; k < 6; k++) begin
                if (o[10-k]) begin
                    nload++;
                    seq_code = seq_code * 10 + (k < 3 ? k + 1 : k + 1);
                end
            end
            if (nload > 1) multi++;
            if (o[4]) begin
                n_upd++;
                if (upd_cyc < 0) upd_cyc = cyc;
            end
            if (o[0]) begin
                n_clr++;
                if (clr_cyc < 0) clr_cyc = cyc;
            end
        end
        // load codes: 1/2/3 = pcard1..3, 4/5/6 = dcard1..3
        exp_code = 1425;
        if (e_p3) exp_code = exp_code * 10 + 3;
        if (e_d3) exp_code = exp_code * 10 + 6;
        exp_flags = (e_res == 0) ? 3'b100 : (e_res == 1) ? 3'b010 : 3'b001;
        check($sformatf("%s/load_order", name), 32'(seq_code), 32'(exp_code));
        check($sformatf("%s/one_load_per_cycle", name), 32'(multi), 32'd0);
        check($sformatf("%s/update_count", name), 32'(n_upd), 32'd1);
        check($sformatf("%s/update_latency", name), 32'(upd_cyc), 32'(e_lat));
`ifdef AUTO_NEXT_ROUND_EN
        check($sformatf("%s/clear_cycle", name), 32'(clr_cyc), 32'(e_lat + 1 + int'(HOLD)));
        check($sformatf("%s/clear_count", name), 32'(n_clr), 32'd1);
        check($sformatf("%s/flags_after_clear", name), 32'(o[3:1]), 32'd0);
        check($sformatf("%s/back_in_idle", name), 32'(o[11]), 32'd1);
`else
        check($sformatf("%s/clear_count", name), 32'(n_clr), 32'd0);
        check($sformatf("%s/result_flags", name), 32'(o[3:1]), 32'(exp_flags));
        check($sformatf("%s/done_no_bet", name), 32'(o[11]), 32'd0);
`endif
        bus.start = 1'b0;
    endtask

    typedef struct {
        string           name;
        logic [5:0][3:0] cards;
        bit              p3;
        bit              d3;
        int              res;
        int              lat;
    } vec_t;

    vec_t tbl[8];

    initial begin
        bit              p3, d3;
        int              res, lat;
        logic [5:0][3:0] c;

        bus.start = 1'b0;
        deck = '0;

        // cards are dealt P1, D1, P2, D2, then the next card(s) for any third draws
        tbl[0] = '{"natural",        mk(9, 2, 13, 3, 1, 1),  1'b0, 1'b0, 0, 7};
        tbl[1] = '{"player_draws",   mk(2, 4, 3, 2, 7, 5),   1'b1, 1'b1, 0, 10};
        tbl[2] = '{"player_stands",  mk(3, 2, 3, 2, 4, 1),   1'b0, 1'b1, 1, 9};
        tbl[3] = '{"banker3_v8",     mk(1, 1, 1, 2, 8, 9),   1'b1, 1'b0, 1, 9};
        tbl[4] = '{"tie",            mk(10, 13, 7, 7, 1, 1), 1'b0, 1'b0, 2, 8};
        tbl[5] = '{"banker_natural", mk(1, 4, 2, 4, 1, 1),   1'b0, 1'b0, 1, 7};
        tbl[6] = '{"banker3_face",   mk(2, 1, 2, 2, 12, 6),  1'b1, 1'b1, 1, 10};
        tbl[7] = '{"banker6_v5",     mk(1, 3, 4, 3, 5, 9),   1'b1, 1'b0, 1, 9};

        for (int i = 0; i < 8; i++)
            run_round(tbl[i].name, tbl[i].cards, 1'b1, tbl[i].p3, tbl[i].d3, tbl[i].res, tbl[i].lat);

        // reset arriving while D1 is being dealt
        deck = tbl[1].cards;
        reset_dut();
        @(posedge slow_clock); #1;
        bus.start = 1'b1;
        @(posedge slow_clock); #1;
        @(posedge slow_clock); #1;
        check("mid_deal/in_d1", 32'(bus.load_dcard1), 32'd1);
        resetb = 1'b0;
        bus.start = 1'b0;
        #2;
        check("mid_deal/async_reset", 32'(outs()), 32'h800);
        @(posedge slow_clock); #1;
        check("mid_deal/held_in_reset", 32'(outs()), 32'h800);
        resetb = 1'b1;
        @(posedge slow_clock); #1;
        check("mid_deal/reset_exit", 32'(outs()), 32'h800);
        run_round("after_mid_reset", tbl[0].cards, 1'b0, tbl[0].p3, tbl[0].d3, tbl[0].res, tbl[0].lat);

        // random rounds scored by the rules model
        for (int r = 0; r < 60; r++) begin
            for (int k = 0; k < 6; k++) c[k] = 4'($urandom_range(13, 1));
            model(c, p3, d3, res, lat);
            run_round($sformatf("rand%0d", r), c, 1'b1, p3, d3, res, lat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
